// File: rtl/weight_loader.sv
// weight_loader: write-side producer for one layer's per-neuron weight
// memories. A neuron-select command opens a load, then a valid/ready word
// stream is written word-by-word into the selected neuron's memory.
// Optional feature macro: WLOAD_BIAS_EN (one extra bias word per load,
// written through the bias_wen one-hot enable).
module weight_loader #(
  parameter int numWeight    = 784,
  parameter int numNeurons   = 30,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int selWidth     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  input  logic [selWidth-1:0]     sel_neuron,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [dataWidth-1:0]    s_data,
  input  logic                    s_last,
  output logic [numNeurons-1:0]   wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    load_done,
  output logic                    err,
  output logic                    busy
`ifdef WLOAD_BIAS_EN
  ,
  output logic [numNeurons-1:0]   bias_wen
`endif
);

  // One spare counter bit so the bias index (numWeight) is representable.
  localparam int cntWidth = addressWidth + 1;
`ifdef WLOAD_BIAS_EN
  localparam int lastInt = numWeight;
`else
  localparam int lastInt = numWeight - 1;
`endif
  localparam logic [cntWidth-1:0]   lastIdx     = cntWidth'(lastInt);
  localparam logic [selWidth:0]     neuronLimit = (selWidth + 1)'(numNeurons);
  localparam logic [numNeurons-1:0] oneHotBase  = numNeurons'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [selWidth-1:0]     sel_q, sel_d;
  logic [cntWidth-1:0]     cnt_q, cnt_d;
  logic [numNeurons-1:0]   wen_q, wen_d;
  logic [addressWidth-1:0] wadd_q, wadd_d;
  logic [dataWidth-1:0]    win_q, win_d;
  logic                    load_done_q, load_done_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    sel_ready_q, sel_ready_d;
  logic                    s_ready_q, s_ready_d;
  logic                    sel_take, word_take;
`ifdef WLOAD_BIAS_EN
  logic [numNeurons-1:0]   bias_wen_q, bias_wen_d;
`endif

  assign sel_take  = sel_valid & sel_ready_q;
  assign word_take = s_valid & s_ready_q;

  // Next-state and next-output computation; handshakes use the registered
  // ready flags so the outside world and the FSM agree on every transfer.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    wen_d       = '0;
    wadd_d      = wadd_q;
    win_d       = win_q;
    load_done_d = 1'b0;
    err_d       = err_q;
`ifdef WLOAD_BIAS_EN
    bias_wen_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (sel_take) begin
          if ({1'b0, sel_neuron} < neuronLimit) begin
            sel_d   = sel_neuron;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (word_take) begin
`ifdef WLOAD_BIAS_EN
          if (cnt_q == lastIdx) begin
            bias_wen_d = oneHotBase << sel_q;
            win_d      = s_data;
          end else begin
            wen_d  = oneHotBase << sel_q;
            wadd_d = cnt_q[addressWidth-1:0];
            win_d  = s_data;
          end
`else
          wen_d  = oneHotBase << sel_q;
          wadd_d = cnt_q[addressWidth-1:0];
          win_d  = s_data;
`endif
          if (cnt_q == lastIdx) begin
            if (s_last) begin
              state_d = DONE;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (s_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (word_take && s_last) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        load_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The completion pulse cycle keeps sel_ready low so it reads as DONE.
    sel_ready_d = (state_d == IDLE) && (state_q != DONE);
    s_ready_d   = (state_d == LOAD) || (state_d == DRAIN);
    busy_d      = (state_d == LOAD);
  end

  // State and registered outputs; reset abandons any partial load at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      wen_q       <= '0;
      wadd_q      <= '0;
      win_q       <= '0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      sel_ready_q <= 1'b1;
      s_ready_q   <= 1'b0;
`ifdef WLOAD_BIAS_EN
      bias_wen_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      wen_q       <= wen_d;
      wadd_q      <= wadd_d;
      win_q       <= win_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      sel_ready_q <= sel_ready_d;
      s_ready_q   <= s_ready_d;
`ifdef WLOAD_BIAS_EN
      bias_wen_q  <= bias_wen_d;
`endif
    end
  end

  assign sel_ready = sel_ready_q;
  assign s_ready   = s_ready_q;
  assign wen       = wen_q;
  assign wadd      = wadd_q;
  assign win       = win_q;
  assign load_done = load_done_q;
  assign err       = err_q;
  assign busy      = busy_q;
`ifdef WLOAD_BIAS_EN
  assign bias_wen  = bias_wen_q;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: randomized loads checked against a transaction-level
// model of which words should land in which neuron memory, and when.
module tb_weight_loader;
  localparam int NW = 4;
  localparam int NN = 30;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel_valid;
  logic          sel_ready;
  logic [SW-1:0] sel_neuron;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic [NN-1:0] wen;
  logic [AW-1:0] wadd;
  logic [DW-1:0] win;
  logic          load_done;
  logic          err;
  logic          busy;

  weight_loader #(
    .numWeight(NW), .numNeurons(NN), .addressWidth(AW),
    .dataWidth(DW), .selWidth(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_neuron(sel_neuron),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .wen(wen), .wadd(wadd), .win(win),
    .load_done(load_done), .err(err), .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cycle == k.
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NN-1:0] wen;
    logic [AW-1:0] wadd;
    logic [DW-1:0] win;
    int            edgeIdx;
  } wr_t;

  wr_t wrQ[$];
  int  doneQ[$];

  // Passive monitor: log every memory write and every completion pulse.
  always @(negedge clk) begin
    if (wen != '0) wrQ.push_back('{wen, wadd, win, cycle});
    if (load_done) doneQ.push_back(cycle);
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // All driving happens just after the falling edge.
  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic doSelect(input int neuron);
    checkOutput("sel_ready_before_select", sel_ready, 1);
    sel_valid  = 1'b1;
    sel_neuron = SW'(neuron);
    stepCycle();
    sel_valid  = 1'b0;
    if (neuron < NN) begin
      checkOutput("select_err_cleared", err, 0);
      checkOutput("select_busy", busy, 1);
      checkOutput("select_sel_ready", sel_ready, 0);
      checkOutput("select_s_ready", s_ready, 1);
    end else begin
      checkOutput("bad_select_err", err, 1);
      checkOutput("bad_select_sel_ready", sel_ready, 1);
      checkOutput("bad_select_busy", busy, 0);
      checkOutput("bad_select_s_ready", s_ready, 0);
    end
  endtask

  // Offers one word after a gap (with stray select attempts during the gap)
  // and returns the rising-edge index at which it was accepted.
  task automatic sendWord(input logic [DW-1:0] data, input logic last,
                          input int minGap, input int maxGap,
                          output int acceptEdge);
    int gap;
    int waitN;
    gap = $urandom_range(maxGap, minGap);
    acceptEdge = -1;
    repeat (gap) begin
      s_valid    = 1'b0;
      sel_valid  = 1'($urandom_range(1, 0));
      sel_neuron = SW'($urandom_range(NN - 1, 0));
      stepCycle();
    end
    sel_valid = 1'b0;
    s_valid   = 1'b1;
    s_data    = data;
    s_last    = last;
    waitN     = 0;
    while (!s_ready && waitN < 10) begin
      stepCycle();
      waitN++;
    end
    if (!s_ready) checkOutput("s_ready_timeout", s_ready, 1);
    else acceptEdge = cycle + 1;
    stepCycle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // One complete transaction: select, then lastPos+1 words with s_last on
  // the final one; the model derives writes, err and load_done from that.
  task automatic applyStimulus(input int neuron, input int lastPos,
                               input int minGap, input int maxGap);
    logic [DW-1:0] words[8];
    int            accEdge[8];
    int            nWrites;
    bit            expErr;
    bit            expDone;
    logic [NN-1:0] expWen;
    logic [NN-1:0] one;
    wrQ.delete();
    doneQ.delete();
    doSelect(neuron);
    if (neuron < NN) begin
      for (int i = 0; i <= lastPos; i++) begin
        words[i] = DW'($urandom);
        sendWord(words[i], (i == lastPos), minGap, maxGap, accEdge[i]);
      end
      checkOutput("post_last_sel_ready", sel_ready, (lastPos != NW - 1) ? 1 : 0);
    end
    repeat (4) stepCycle();

    nWrites = (neuron >= NN) ? 0 : ((lastPos + 1 < NW) ? lastPos + 1 : NW);
    expDone = (neuron < NN) && (lastPos == NW - 1);
    expErr  = !expDone;
    one     = 1;
    expWen  = one << neuron;

    checkOutput("write_count", wrQ.size(), nWrites);
    for (int i = 0; i < nWrites && i < wrQ.size(); i++) begin
      checkOutput("write_wen", wrQ[i].wen, expWen);
      checkOutput("write_wadd", wrQ[i].wadd, i);
      checkOutput("write_win", wrQ[i].win, words[i]);
      checkOutput("write_timing", wrQ[i].edgeIdx, accEdge[i]);
    end
    checkOutput("done_count", doneQ.size(), expDone ? 1 : 0);
    if (expDone && doneQ.size() > 0)
      checkOutput("done_latency", doneQ[0], accEdge[NW - 1] + 1);
    checkOutput("final_err", err, expErr);
    checkOutput("final_sel_ready", sel_ready, 1);
    checkOutput("final_busy", busy, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_sel_ready"}, sel_ready, 1);
    checkOutput({tag, "_s_ready"}, s_ready, 0);
    checkOutput({tag, "_wen"}, wen, 0);
    checkOutput({tag, "_wadd"}, wadd, 0);
    checkOutput({tag, "_win"}, win, 0);
    checkOutput({tag, "_load_done"}, load_done, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            dummyEdge;
    int            nrn;
    int            lp;
    logic [NN-1:0] one;
    one        = 1;
    rst        = 1'b1;
    sel_valid  = 1'b0;
    sel_neuron = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    repeat (3) stepCycle();
    checkResetValues("reset");
    rst = 1'b0;
    stepCycle();

    // Words offered while idle have no effect.
    wrQ.delete();
    s_valid = 1'b1;
    s_data  = 16'hBEEF;
    s_last  = 1'b1;
    repeat (3) stepCycle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    checkOutput("idle_words_ignored", wrQ.size(), 0);
    checkOutput("idle_s_ready", s_ready, 0);

    applyStimulus(2, NW - 1, 0, 0);
    applyStimulus(2, NW - 1, 2, 2);
    applyStimulus(31, NW - 1, 0, 0);
    applyStimulus(30, NW - 1, 0, 0);
    applyStimulus(29, NW - 1, 0, 1);
    applyStimulus(5, 1, 0, 1);
    applyStimulus(7, NW + 2, 0, 1);
    applyStimulus(0, 0, 0, 0);

    // Reset in the middle of a load.
    wrQ.delete();
    doSelect(3);
    sendWord(16'h0011, 1'b0, 0, 0, dummyEdge);
    sendWord(16'h0022, 1'b0, 0, 0, dummyEdge);
    checkOutput("pre_reset_wen", wen, one << 3);
    rst = 1'b1;
    #1;
    checkResetValues("mid_reset");
    stepCycle();
    rst = 1'b0;
    stepCycle();
    checkOutput("reset_write_count", wrQ.size(), 2);
    applyStimulus(0, NW - 1, 0, 0);

    // Randomized loads, biased toward well-formed ones.
    for (int t = 0; t < 25; t++) begin
      nrn = $urandom_range(31, 0);
      lp  = ($urandom_range(1, 0) == 1) ? NW - 1 : $urandom_range(NW + 2, 0);
      applyStimulus(nrn, lp, 0, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
Streams pretrained or host-supplied weights into per-neuron weight memories when the design is built without preloaded weight files. The block is the write-side producer for those memories: it accepts a neuron-select command, then a valid/ready word stream. It drives a one-hot write enable, a write address and a data word into the selected neuron's memory, and signals completion. One instance sits per layer, between the configuration interface and that layer's neurons.

Parameters:
numWeight, 784, words per neuron memory (one load transfers exactly this many)
numNeurons, 30, neurons in the layer (width of the one-hot enable)
addressWidth, 10, memory write-address width; must satisfy 2^addressWidth >= numWeight
dataWidth, 16, weight word width
selWidth, 5, neuron-select width; must satisfy 2^selWidth >= numNeurons

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
sel_valid  in  1  neuron-select command valid
sel_ready  out  1  block can accept a select command
sel_neuron  in  selWidth  target neuron index
s_valid  in  1  weight word valid
s_ready  out  1  block accepts weight word this cycle
s_data  in  dataWidth  weight word
s_last  in  1  marks final word of the load
wen  out  numNeurons  one-hot write enable to neuron memories
wadd  out  addressWidth  write address
win  out  dataWidth  write data
load_done  out  1  one-cycle pulse: load completed cleanly
err  out  1  sticky error flag, cleared by rst or by the next accepted select
busy  out  1  load in progress

Behaviour:
- Reset (asynchronous, immediate): state IDLE; sel_ready=1; s_ready=0; wen=0; wadd=0; win=0; load_done=0; err=0; busy=0; word counter=0.
- Select handshake: a select is taken when sel_valid & sel_ready.
- States:
  - IDLE: sel_ready=1, s_ready=0. On select with sel_neuron < numNeurons: latch the index, clear the counter, clear err, go to LOAD. On select with sel_neuron >= numNeurons: set err and stay in IDLE.
  - LOAD: sel_ready=0, s_ready=1, busy=1. A word is accepted when s_valid & s_ready. Each accepted word at cycle N registers wen[sel]=1, wadd=counter, win=s_data, visible in cycle N+1 for exactly one cycle. The counter then increments.
  - Word counter = numWeight-1 with s_last=1: write that word, then go to DONE.
  - Word counter = numWeight-1 with s_last=0: write that word, set err, go to DRAIN.
  - s_last=1 with counter < numWeight-1: write that word, set err, go to IDLE (short load; no load_done).
  - DRAIN: s_ready=1, no writes. Discard words until an accepted word has s_last=1, then go to IDLE.
  - DONE: load_done=1 for one cycle, sel_ready=0, s_ready=0, then go to IDLE.
- Write timing: wen is zero in every cycle without an accepted word the cycle before. s_valid with s_ready=0 has no effect. Backpressure is never applied during LOAD.
- wadd never exceeds numWeight-1; the counter never wraps inside a load.
- sel_valid during LOAD, DRAIN or DONE is ignored (sel_ready=0), not queued.
- Reset mid-load: wen drops immediately and the partial load is abandoned; memory contents written so far are unchanged.
- Latency: last accepted word to load_done is 2 cycles (write cycle, then DONE).

Optional Feature:
Macro: WLOAD_BIAS_EN.
- When defined:
  - Add output port bias_wen (numNeurons, one-hot).
  - A load is numWeight+1 words; word index numWeight is the bias.
  - The bias word drives bias_wen[sel]=1 and win=bias for one cycle, with wen=0 and wadd held.
  - s_last is expected on the bias word; the short, long and DRAIN rules apply with numWeight+1 as the length.
- When undefined: no bias_wen port; a load is exactly numWeight words.

Test Plan:
- numWeight=4, select neuron 2, words 0x0011,0x0022,0x0033,0x0044 back-to-back with s_last on the 4th -> wen=0b...100 on 4 consecutive cycles, wadd 0..3, win matches the words; load_done pulses 2 cycles after the last acceptance; err=0.
- Same load with s_valid gaps of 2 cycles between words -> exactly 4 wen pulses, addresses 0..3, no duplicate writes.
- Select neuron 31 with numNeurons=30 -> err=1, state stays IDLE, no wen; a following valid select clears err.
- s_last on the 2nd word -> writes at wadd 0,1 only; err=1; no load_done; sel_ready=1 the next cycle.
- No s_last on the 4th word, followed by 3 extra words with s_last on the last -> 4 writes only, err=1, extras drained, return to IDLE.
- rst asserted after 2 of 4 words -> wen=0 in the same cycle, all outputs at reset values; a new full load to neuron 0 then succeeds.
